// File: rtl/scope_capture_if.sv
// Sample-stream and record-read bus of the scope capture stage.
// master: the XADC reader / display side. slave: the capture block.
interface scope_capture_if #(
   parameter int ADDR_W = 10
);
   logic              sample_valid;
   logic [1:0][11:0]  sample_data;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [1:0][11:0]  rd_data;
   logic              rd_valid;

   modport master (
      output sample_valid, sample_data, rd_en, rd_addr,
      input  rd_data, rd_valid
   );

   modport slave (
      input  sample_valid, sample_data, rd_en, rd_addr,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/scope_capture.sv
// Trigger-and-capture stage: writes samples into a circular record, waits
// for an edge (or forced) trigger after a pre-trigger fill, completes the
// post-trigger fill, then freezes and serves trigger-relative reads.
module scope_capture #(
   parameter int DEPTH   = 1024,
   parameter int PRETRIG = 256,
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   scope_capture_if.slave      bus,
   input  logic                arm,
   input  logic                force_trig,
   input  logic                trig_channel,
   input  logic [11:0]         trig_level,
   input  logic                trig_rising,
   output logic                busy,
   output logic                triggered,
   output logic                done
);

   typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;

   // Samples still owed after the trigger sample itself.
   localparam int                POST_N    = DEPTH - PRETRIG - 1;
   localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
   localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
   localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic              pending, pending_nxt;
   logic              triggered_nxt;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] start_ptr;
   logic [1:0][11:0]  last_sample;
   logic [1:0][11:0]  mem [DEPTH];

   logic              capturing;
   logic              wr_en;
   logic [11:0]       cur, prev;
   logic              edge_hit;
   logic              hit;
   logic              rd_ok;

   // arm takes priority over a coincident sample, so that sample never lands.
   assign capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
   assign wr_en     = bus.sample_valid && capturing && !arm;

   // prev always comes from the last written sample, so the first WAIT_TRIG
   // sample compares against the final PRE sample.
   assign cur  = bus.sample_data[trig_channel];
   assign prev = last_sample[trig_channel];

   assign edge_hit = trig_rising ? ((prev < trig_level) && (cur >= trig_level))
                                 : ((prev > trig_level) && (cur <= trig_level));

   // A pending force, or a force in the same cycle, turns this sample into the hit.
   assign hit = wr_en && (state == WAIT_TRIG) && (edge_hit || pending || force_trig);

   assign busy  = capturing;
   assign done  = (state == DONE);
   assign rd_ok = bus.rd_en && (state == DONE);

   // Next-state, counter, pending-force and triggered-flag logic.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pending_nxt   = pending;
      triggered_nxt = triggered;
      if (arm) begin
         state_nxt     = PRE;
         cnt_nxt       = '0;
         pending_nxt   = 1'b0;
         triggered_nxt = 1'b0;
      end else begin
         case (state)
            PRE: begin
               if (wr_en) begin
                  if (cnt == PRE_LAST) begin
                     state_nxt = WAIT_TRIG;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt + ADDR_W'(1);
                  end
               end
            end
            WAIT_TRIG: begin
               if (hit) begin
                  triggered_nxt = 1'b1;
                  pending_nxt   = 1'b0;
                  cnt_nxt       = '0;
                  state_nxt     = (POST_N == 0) ? DONE : POST;
               end else if (force_trig) begin
                  pending_nxt = 1'b1;
               end
            end
            POST: begin
               if (wr_en) begin
                  if (cnt == POST_LAST) begin
                     state_nxt = DONE;
                  end else begin
                     cnt_nxt = cnt + ADDR_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Control state, write pointer, trigger origin and edge history.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         pending     <= 1'b0;
         triggered   <= 1'b0;
         wr_ptr      <= '0;
         start_ptr   <= '0;
         last_sample <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         pending   <= pending_nxt;
         triggered <= triggered_nxt;
         if (wr_en) begin
            wr_ptr      <= wr_ptr + ADDR_W'(1);
            last_sample <= bus.sample_data;
         end
         if (hit)
            start_ptr <= wr_ptr - PRE_OFS;
      end
   end

   // Sample memory write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= bus.sample_data;
   end

   // Registered trigger-relative read, honoured only on a frozen record.
   always_ff @(posedge clk) begin
      if (reset) begin
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
      end else begin
         bus.rd_valid <= rd_ok;
         if (rd_ok)
            bus.rd_data <= mem[start_ptr + bus.rd_addr];
      end
   end

endmodule

// File: tb/tb_scope_capture.sv
// Self-checking bench for scope_capture: ramp/falling/forced captures,
// re-arm behaviour, reset and read gating. Read results go through a
// scoreboard queue that a negedge monitor drains.
module tb_scope_capture;
   localparam int DEPTH   = 16;
   localparam int PRETRIG = 4;
   localparam int ADDR_W  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        arm = 1'b0;
   logic        force_trig = 1'b0;
   logic        trig_channel = 1'b0;
   logic [11:0] trig_level = 12'd450;
   logic        trig_rising = 1'b1;
   logic        busy, triggered, done;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] exp_q[$];
   logic [23:0] exp_v;

   scope_capture_if #(.ADDR_W(ADDR_W)) bus();

   scope_capture #(.DEPTH(DEPTH), .PRETRIG(PRETRIG), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .arm          (arm),
      .force_trig   (force_trig),
      .trig_channel (trig_channel),
      .trig_level   (trig_level),
      .trig_rising  (trig_rising),
      .busy         (busy),
      .triggered    (triggered),
      .done         (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   // ch0 carries the test value, ch1 its complement so both lanes are checked.
   function automatic logic [23:0] pack(input int v);
      logic [11:0] c0, c1;
      c0 = v[11:0];
      c1 = 12'd4095 - c0;
      return {c1, c0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One sample every 4 cycles; returns just after the edge that writes it.
   task automatic send(input int v);
      repeat (3) tick();
      bus.sample_valid = 1'b1;
      bus.sample_data  = pack(v);
      tick();
      bus.sample_valid = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic issue_read(input int a, input int v);
      bus.rd_en   = 1'b1;
      bus.rd_addr = a[ADDR_W-1:0];
      exp_q.push_back(pack(v));
      tick();
   endtask

   task automatic end_reads();
      bus.rd_en = 1'b0;
      repeat (2) tick();
   endtask

   // Scoreboard: every rd_valid must match the oldest outstanding read.
   always @(negedge clk) begin
      if (!reset && bus.rd_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: rd_data=%h with no read outstanding", bus.rd_data);
         end else begin
            exp_v = exp_q.pop_front();
            if (bus.rd_data !== exp_v) begin
               errors++;
               $display("FAIL rd_data: got %h expected %h", bus.rd_data, exp_v);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      checks++;
      if ({busy, triggered, done, bus.rd_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: busy/trig/done/rd_valid=%b expected 0000",
                  {busy, triggered, done, bus.rd_valid});
      end
      checks++;
      if (bus.rd_data !== 24'h0) begin
         errors++;
         $display("FAIL reset_rd_data: got %h expected 000000", bus.rd_data);
      end
   endtask

   task automatic test_ramp();
      trig_level = 12'd450; trig_rising = 1'b1; trig_channel = 1'b0;
      do_arm();
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL ramp_busy: busy=%b expected 1", busy);
      end
      for (int v = 0; v <= 400; v += 100) send(v);
      checks++;
      if (triggered !== 1'b0) begin
         errors++; $display("FAIL ramp_early_trig: triggered=%b expected 0 after 400", triggered);
      end
      send(500);
      checks++;
      if (triggered !== 1'b1) begin
         errors++; $display("FAIL ramp_trig: triggered=%b expected 1 after 500", triggered);
      end
      for (int v = 600; v <= 1500; v += 100) send(v);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL ramp_early_done: done=%b expected 0 after 1500", done);
      end
      send(1600);
      checks++;
      if ({done, busy} !== 2'b10) begin
         errors++; $display("FAIL ramp_done: done/busy=%b expected 10", {done, busy});
      end
      // single read with exact latency, then two back-to-back
      issue_read(0, 100);
      bus.rd_en = 1'b0;
      checks++;
      if (bus.rd_valid !== 1'b1) begin
         errors++; $display("FAIL ramp_rd_latency: rd_valid=%b expected 1", bus.rd_valid);
      end
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0) begin
         errors++; $display("FAIL ramp_rd_pulse: rd_valid=%b expected 0", bus.rd_valid);
      end
      issue_read(4, 500);
      issue_read(15, 1600);
      end_reads();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL ramp_reads_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_falling();
      trig_level = 12'd1050; trig_rising = 1'b0;
      do_arm();
      for (int v = 1500; v >= 1100; v -= 100) send(v);
      checks++;
      if (triggered !== 1'b0) begin
         errors++; $display("FAIL fall_early_trig: triggered=%b expected 0", triggered);
      end
      send(1000);
      checks++;
      if (triggered !== 1'b1) begin
         errors++; $display("FAIL fall_trig: triggered=%b expected 1 after 1000", triggered);
      end
      for (int i = 1; i <= DEPTH - PRETRIG - 1; i++) send((1000 - 100 * i) < 0 ? 0 : 1000 - 100 * i);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL fall_done: done=%b expected 1", done);
      end
      issue_read(4, 1000);
      issue_read(0, 1400);
      issue_read(5, 900);
      end_reads();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL fall_reads_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_pre_edge();
      trig_level = 12'd450; trig_rising = 1'b1;
      do_arm();
      send(300); send(400); send(600); send(600);
      for (int i = 0; i < 3; i++) send(600);
      checks++;
      if ({triggered, busy} !== 2'b01) begin
         errors++; $display("FAIL pre_edge_ignored: trig/busy=%b expected 01", {triggered, busy});
      end
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      checks++;
      if (triggered !== 1'b0) begin
         errors++; $display("FAIL force_no_sample: triggered=%b expected 0", triggered);
      end
      send(600);
      checks++;
      if (triggered !== 1'b1) begin
         errors++; $display("FAIL force_trig: triggered=%b expected 1", triggered);
      end
      for (int i = 0; i < DEPTH - PRETRIG - 1; i++) send(600);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL force_done: done=%b expected 1", done);
      end
      issue_read(4, 600);
      issue_read(0, 600);
      end_reads();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL force_reads_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_rearm();
      trig_level = 12'd450; trig_rising = 1'b1;
      do_arm();
      for (int v = 0; v <= 700; v += 100) send(v);
      do_arm();
      checks++;
      if ({triggered, busy, done} !== 3'b010) begin
         errors++; $display("FAIL rearm_post: trig/busy/done=%b expected 010", {triggered, busy, done});
      end
      // arm together with a sample: that sample must not be counted as PRE
      arm = 1'b1;
      bus.sample_valid = 1'b1;
      bus.sample_data  = pack(4000);
      tick();
      arm = 1'b0;
      bus.sample_valid = 1'b0;
      send(100); send(200); send(300);
      // still in PRE here, so this force must be dropped
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      send(400);
      checks++;
      if (triggered !== 1'b0) begin
         errors++; $display("FAIL arm_sample_dropped: triggered=%b expected 0 after 400", triggered);
      end
      send(500);
      checks++;
      if (triggered !== 1'b1) begin
         errors++; $display("FAIL rearm_trig: triggered=%b expected 1 after 500", triggered);
      end
      for (int v = 600; v <= 1600; v += 100) send(v);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL rearm_done: done=%b expected 1", done);
      end
      issue_read(0, 100);
      issue_read(4, 500);
      issue_read(15, 1600);
      end_reads();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL rearm_reads_missing: %0d outstanding expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset_gating();
      trig_level = 12'd450; trig_rising = 1'b1;
      do_arm();
      for (int v = 0; v <= 400; v += 100) send(v);
      bus.rd_en = 1'b1;
      bus.rd_addr = '0;
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0) begin
         errors++; $display("FAIL gate_wait: rd_valid=%b expected 0", bus.rd_valid);
      end
      bus.rd_en = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({busy, triggered, done, bus.rd_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL midreset_flags: busy/trig/done/rd_valid=%b expected 0000",
                  {busy, triggered, done, bus.rd_valid});
      end
      checks++;
      if (bus.rd_data !== 24'h0) begin
         errors++; $display("FAIL midreset_rd_data: got %h expected 000000", bus.rd_data);
      end
      for (int i = 0; i < 4; i++) begin
         force_trig = 1'b1;
         send((i % 2) ? 1000 : 0);
         force_trig = 1'b0;
         checks++;
         if ({busy, triggered, done} !== 3'b000) begin
            errors++; $display("FAIL idle_hold: busy/trig/done=%b expected 000", {busy, triggered, done});
         end
      end
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      checks++;
      if (bus.rd_valid !== 1'b0) begin
         errors++; $display("FAIL gate_idle: rd_valid=%b expected 0", bus.rd_valid);
      end
   endtask

   initial begin
      bus.sample_valid = 1'b0;
      bus.sample_data  = '0;
      bus.rd_en        = 1'b0;
      bus.rd_addr      = '0;
      test_reset();
      test_ramp();
      test_falling();
      test_pre_edge();
      test_rearm();
      test_reset_gating();
      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scope_capture.md
# scope_capture

Trigger-and-capture stage for the oscilloscope datapath. It consumes the per-sequence sample pulse and two 12-bit channel codes produced by the XADC signal reader, and writes them into a circular sample memory. It detects an edge trigger on a selectable channel, keeps a fixed number of pre-trigger samples, and finishes filling the buffer with post-trigger samples. The frozen record is then exposed through a trigger-relative read port for the display/host stage.

## Interface
Parameters:
- DEPTH, 1024, samples per record; power of two, ≥ 4
- PRETRIG, 256, samples kept before the trigger sample; 1 ≤ PRETRIG ≤ DEPTH-1
- ADDR_W, $clog2(DEPTH), address width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sample_valid  in  1  one-cycle pulse; sample_data valid this cycle
- sample_data  in  [1:0][11:0]  unsigned channel codes, ch0 = [0], ch1 = [1]
- arm  in  1  pulse; starts or restarts a capture
- force_trig  in  1  pulse; requests a trigger without an edge
- trig_channel  in  1  channel compared against trig_level
- trig_level  in  12  unsigned trigger threshold
- trig_rising  in  1  1 = rising edge, 0 = falling edge
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  logical index; 0 = oldest pre-trigger sample, PRETRIG = trigger sample
- rd_data  out  [1:0][11:0]  read result
- rd_valid  out  1  rd_data valid
- busy  out  1  capture in progress (states PRE, WAIT_TRIG, POST)
- triggered  out  1  trigger accepted for the current record
- done  out  1  record complete and frozen

## Operation
States: IDLE, PRE, WAIT_TRIG, POST, DONE.

Sample writes:
- In PRE, WAIT_TRIG and POST, each sample_valid writes sample_data to mem[wr_ptr].
- wr_ptr then increments and wraps modulo DEPTH.
- In IDLE and DONE, nothing is written.

State transitions:
- IDLE → PRE on arm.
- PRE: count samples written. After the PRETRIG-th sample, go to WAIT_TRIG. Edges are ignored in PRE.
- WAIT_TRIG: let cur = sample_data[trig_channel] and prev = the previous accepted sample on trig_channel (taken from the last sample written, including the last PRE sample).
  - Rising hit: prev < trig_level && cur ≥ trig_level.
  - Falling hit: prev > trig_level && cur ≤ trig_level.
- force_trig in WAIT_TRIG sets a pending flag. The next sample_valid, or a sample_valid in the same cycle, is treated as a hit. force_trig outside WAIT_TRIG is ignored.
- On a hit:
  - The hit sample is written; its address is trig_ptr.
  - start_ptr = trig_ptr − PRETRIG (mod DEPTH).
  - triggered is set and the state goes to POST.
- POST: after DEPTH−PRETRIG−1 further samples, go to DONE. If that count is 0, go directly from WAIT_TRIG to DONE.
- DONE: the record is frozen and done = 1.
- arm in any state clears counters, triggered, done and the pending flag, and enters PRE. wr_ptr is not reset.

Read port:
- A read is honoured only in DONE.
- Physical address = start_ptr + rd_addr (mod DEPTH).
- rd_en outside DONE gives rd_valid = 0.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, busy = 0, triggered = 0, done = 0. State = IDLE, wr_ptr = 0, pending = 0.
- The memory array is not reset.
- A sample is written in the same cycle as its sample_valid.
- State and counter updates are registered on that edge.
- busy rises the cycle after arm.
- triggered rises the cycle after the hit sample.
- done rises, and busy falls, the cycle after the final POST sample.
- Read latency is 1 cycle. rd_valid and rd_data are registered from rd_en/rd_addr and are inferrable as BRAM.
- Back-to-back reads run at one per cycle.
- arm and sample_valid in the same cycle: arm wins and the sample is not written.
- reset mid-capture: returns to IDLE next cycle and all outputs clear.
- prev is undefined before the first sample after arm. The PRE phase guarantees at least one sample, so no false hit can occur on the first WAIT_TRIG sample.

## Test plan
Bench parameters: DEPTH=16, PRETRIG=4. Stimulus is a ch0 ramp of 0, 100, 200, …, one sample_valid every 4 cycles, with trig_level=450, rising, ch0.

- Ramp capture:
  - triggered rises after sample 500.
  - done follows sample 1600.
  - Reads 0, 4 and 15 return ch0 values 100, 500 and 1600, each with rd_valid one cycle after rd_en.
- Falling edge: ramp 1500, 1400, … with level 1050 → trigger sample 1000; read 4 = 1000, read 0 = 1400.
- Ignored PRE edge: crossing occurs at sample 2 with the ramp then flat at 600 → never triggers. A force_trig then produces a trigger on the next sample, and read 4 = 600.
- Re-arm: arm pulsed in POST → triggered=0, busy=1, and a fresh record completes. arm coincident with sample_valid → that sample is absent from the record.
- Reset and read gating:
  - reset in WAIT_TRIG → all outputs 0 next cycle and the block stays IDLE while sample_valid keeps toggling.
  - rd_en while not DONE → rd_valid stays 0.
